regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between `NumReq` writeback requesters (e.g. ALU result path and load-return path) using round-robin arbitration with a valid/ready handshake. Drives the register file's `RegWrite`, `writeRegister` and `WriteData` inputs from a registered output stage. Keeps a pending-write scoreboard so the issue stage can detect read-after-write hazards on source registers. Sits between the execute/memory writeback paths and the register file.

---
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port,
// with a pending-write scoreboard for RAW hazard detection.
module regfile_write_arbiter #(
  parameter int WordLen   = 32,
  parameter int WordCount = 32,
  parameter int NumReq    = 2,
  localparam int AW       = $clog2(WordCount),
  localparam int PW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NumReq-1:0]         reqValid,
  input  logic [NumReq*AW-1:0]      reqAddr,
  input  logic [NumReq*WordLen-1:0] reqData,
  output logic [NumReq-1:0]         reqReady,
  output logic                      RegWrite,
  output logic [AW-1:0]             writeRegister,
  output logic [WordLen-1:0]        WriteData,
  input  logic                      reserveValid,
  input  logic [AW-1:0]             reserveAddr,
  input  logic [AW-1:0]             querySrc1,
  input  logic [AW-1:0]             querySrc2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic [WordCount-1:0]      busy
);

  logic [PW-1:0]        rrPtr;
  logic [PW-1:0]        grantIdx;
  logic [PW-1:0]        nextPtr;
  logic [PW:0]          sum;
  logic                 found;
  logic [AW-1:0]        grantAddr;
  logic [WordLen-1:0]   grantData;
  logic [WordCount-1:0] busyNext;

  always_comb begin
    reqReady = '0;
    grantIdx = '0;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum = {1'b0, rrPtr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NumReq))
        sum = sum - (PW+1)'(NumReq);
      if (!found && reqValid[sum[PW-1:0]]) begin
        found    = 1'b1;
        grantIdx = sum[PW-1:0];
      end
    end
    if (found)
      reqReady[grantIdx] = 1'b1;
  end

  always_comb begin
    grantAddr = '0;
    grantData = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (reqReady[i]) begin
        grantAddr = reqAddr[i*AW +: AW];
        grantData = reqData[i*WordLen +: WordLen];
      end
    end
  end

  assign nextPtr = (grantIdx == PW'(NumReq-1)) ? '0 : grantIdx + 1'b1;

  // set is applied after clear so a same-cycle re-reserve wins
  always_comb begin
    busyNext = busy;
    if (RegWrite)
      busyNext[writeRegister] = 1'b0;
    if (reserveValid && reserveAddr != '0)
      busyNext[reserveAddr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  assign hazard1 = busy[querySrc1];
  assign hazard2 = busy[querySrc2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr         <= '0;
      RegWrite      <= 1'b0;
      writeRegister <= '0;
      WriteData     <= '0;
      busy          <= '0;
    end else begin
      if (found) begin
        rrPtr         <= nextPtr;
        writeRegister <= grantAddr;
        WriteData     <= grantData;
        RegWrite      <= |grantAddr;
      end else begin
        RegWrite <= 1'b0;
      end
      busy <= busyNext;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a
// behavioural arbiter/scoreboard model.
module tb_regfile_write_arbiter;

  localparam int WL = 32;
  localparam int WC = 32;
  localparam int N  = 2;
  localparam int AW = 5;

  logic            clk = 0;
  logic            rst_n = 0;
  logic [N-1:0]    reqValid = '0;
  logic [N*AW-1:0] reqAddr = '0;
  logic [N*WL-1:0] reqData = '0;
  logic [N-1:0]    reqReady;
  logic            RegWrite;
  logic [AW-1:0]   writeRegister;
  logic [WL-1:0]   WriteData;
  logic            reserveValid = 0;
  logic [AW-1:0]   reserveAddr = '0;
  logic [AW-1:0]   querySrc1 = '0;
  logic [AW-1:0]   querySrc2 = '0;
  logic            hazard1;
  logic            hazard2;
  logic [WC-1:0]   busy;

  regfile_write_arbiter #(.WordLen(WL), .WordCount(WC), .NumReq(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady),
    .RegWrite(RegWrite), .writeRegister(writeRegister),
    .WriteData(WriteData),
    .reserveValid(reserveValid), .reserveAddr(reserveAddr),
    .querySrc1(querySrc1), .querySrc2(querySrc2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  int          mRr;
  logic [31:0] mBusy;
  logic        mRw;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  int          lastGrant;

  logic        pv [N];
  logic [4:0]  pa [N];
  logic [31:0] pd [N];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mReset();
    mRr = 0; mBusy = 0; mRw = 0; mAddr = 0; mData = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      reqValid[i] = pv[i];
      reqAddr[i*AW +: AW] = pa[i];
      reqData[i*WL +: WL] = pd[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] expRdy;
    logic [31:0]  nb;
    int           i;
    #1;
    lastGrant = -1;
    for (int k = 0; k < N; k++) begin
      i = (mRr + k) % N;
      if (lastGrant < 0 && reqValid[i]) lastGrant = i;
    end
    expRdy = '0;
    if (lastGrant >= 0) expRdy[lastGrant] = 1'b1;
    chk("reqReady", 64'(reqReady), 64'(expRdy));
    chk("hazard1", 64'(hazard1), 64'(mBusy[querySrc1]));
    chk("hazard2", 64'(hazard2), 64'(mBusy[querySrc2]));
    nb = mBusy;
    if (mRw) nb[mAddr] = 1'b0;
    if (reserveValid && reserveAddr != 0) nb[reserveAddr] = 1'b1;
    mBusy = nb;
    if (lastGrant >= 0) begin
      mAddr = reqAddr[lastGrant*AW +: AW];
      mData = reqData[lastGrant*WL +: WL];
      mRw   = (mAddr != 0);
      mRr   = (lastGrant + 1) % N;
    end else begin
      mRw = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("RegWrite", 64'(RegWrite), 64'(mRw));
    chk("writeRegister", 64'(writeRegister), 64'(mAddr));
    chk("WriteData", 64'(WriteData), 64'(mData));
    chk("busy", 64'(busy), 64'(mBusy));
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pa[i] = 0; pd[i] = 0;
    end
    reserveValid = 0;
    drive();
  endtask

  task automatic doReset();
    rst_n = 0;
    #1;
    mReset();
    chk("rst_RegWrite", 64'(RegWrite), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_WriteData", 64'(WriteData), 64'(0));
    chk("rst_writeRegister", 64'(writeRegister), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    doReset();
    chk("idle_ready", 64'(reqReady), 64'(0));

    // single request: r5 <= DEADBEEF
    pv[0] = 1; pa[0] = 5; pd[0] = 32'hDEADBEEF; drive();
    step();
    chk("single_rw", 64'(RegWrite), 64'(1));
    chk("single_addr", 64'(writeRegister), 64'(5));
    chk("single_data", 64'(WriteData), 64'hDEADBEEF);
    idle(); step();
    chk("single_rw_drop", 64'(RegWrite), 64'(0));

    // contention: grants alternate 0,1,0,1 from reset
    doReset();
    pv[0] = 1; pa[0] = 3; pd[0] = 32'h1111;
    pv[1] = 1; pa[1] = 9; pd[1] = 32'h2222; drive();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("contend_grant", 64'(lastGrant), 64'(c % 2));
    end

    // register 0 write: handshake but no RegWrite
    idle();
    pv[1] = 1; pa[1] = 0; pd[1] = 32'h1234; drive();
    step();
    chk("r0_grant", 64'(lastGrant), 64'(1));
    chk("r0_rw", 64'(RegWrite), 64'(0));
    idle();
    pv[0] = 1; pv[1] = 1; pa[0] = 2; pa[1] = 4; drive();
    step();
    chk("r0_rrptr", 64'(lastGrant), 64'(0));

    // scoreboard: reserve r7, hazard, commit with re-reserve
    idle();
    reserveValid = 1; reserveAddr = 7; step();
    reserveValid = 0; querySrc1 = 7; querySrc2 = 6; step();
    chk("sb_hazard1", 64'(hazard1), 64'(1));
    chk("sb_hazard2", 64'(hazard2), 64'(0));
    pv[0] = 1; pa[0] = 7; pd[0] = 32'hCAFE; drive(); step();
    idle(); reserveValid = 1; reserveAddr = 7; step();
    chk("sb_setwins", 64'(busy[7]), 64'(1));
    reserveAddr = 0; step();
    chk("sb_r0", 64'(busy[0]), 64'(0));
    reserveValid = 0;
    pv[1] = 1; pa[1] = 7; pd[1] = 32'hBEEF; drive(); step();
    idle(); step();
    chk("sb_clear", 64'(busy[7]), 64'(0));

    // reset mid-operation
    reserveValid = 1; reserveAddr = 7; step();
    reserveAddr = 11; pv[0] = 1; pa[0] = 3; pd[0] = 32'h55; drive();
    step();
    chk("mid_rw", 64'(RegWrite), 64'(1));
    chk("mid_busy", 64'(busy), 64'h880);
    idle();
    #2;
    doReset();
    pv[0] = 1; pv[1] = 1; pa[0] = 1; pa[1] = 2; drive();
    step();
    chk("mid_rrptr", 64'(lastGrant), 64'(0));
    idle();

    // randomized traffic, requesters hold until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 3) != 0) begin
          pv[i] = 1;
          pa[i] = 5'($urandom % 32);
          pd[i] = $urandom;
        end
      end
      drive();
      reserveValid = ($urandom % 2) == 1;
      reserveAddr  = 5'($urandom % 32);
      querySrc1    = 5'($urandom % 32);
      querySrc2    = 5'($urandom % 32);
      step();
      if (lastGrant >= 0) pv[lastGrant] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
